dm_ctrl: RTL and testbench

//  Data-memory access controller directly downstream of the address register.
//  - Consumes dm_addr plus the dm_r/dm_wr strobes.
//  - Sequences a wait-stated single-port SRAM access.
//  - Returns read data with a one-cycle done pulse.
//  - Holds busy so the control unit stalls until the access retires.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_parity.sv | 20 ++
 rtl/dm_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dm_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Optional feature macro: PARITY_CHK_EN. When it is defined, the SRAM word
// carries one extra even-parity bit (PAR_W = 1). Otherwise PAR_W = 0.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } dm_state_e;

  localparam int unsigned DM_ADDR_W = 20;
  localparam int unsigned DM_DATA_W = 8;
  localparam int unsigned WAIT_W    = 4;

`ifdef PARITY_CHK_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

endpackage

// File: rtl/dm_parity.sv
// Even-parity generator/checker for the SRAM word (used only with PARITY_CHK_EN).
// Ports:
//   wr_data  in  DATA_W    data word about to be written
//   wr_par   out 1         even-parity bit to store alongside wr_data
//   rd_word  in  DATA_W+1  word read back from SRAM, parity in the MSB
//   rd_bad   out 1         high when rd_word fails the even-parity check
module dm_parity #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_par,
  input  logic [DATA_W:0]   rd_word,
  output logic              rd_bad
);

  // Even parity: the stored bit makes the XOR of the whole word zero.
  assign wr_par = ^wr_data;
  assign rd_bad = ^rd_word;

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: accepts a read or write request from the
// address register, runs a wait-stated single-port SRAM access and retires it
// with a one-cycle done pulse. busy stalls the control unit meanwhile.
// Optional feature macro: PARITY_CHK_EN (even parity on the SRAM word).
// Ports:
//   clock, rst           clock and asynchronous active-high reset
//   dm_addr, dm_r, dm_wr request address and read/write strobes
//   wr_data              write data sampled with dm_wr
//   rd_data              last read word, held until the next read
//   busy, done           access in progress / retire pulse
//   addr_err, conflict   out-of-range access / simultaneous r+wr pulses
//   mem_ce, mem_we       SRAM chip and write enables
//   mem_addr, mem_wdata  latched SRAM address and write word
//   mem_rdata            SRAM read word, valid on the final access cycle
//   par_err              parity error pulse with done (0 without PARITY_CHK_EN)
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W   = DM_ADDR_W,
  parameter int unsigned DATA_W   = DM_DATA_W,
  parameter int unsigned DEPTH    = 1048576,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       dm_addr,
  input  logic                    dm_r,
  input  logic                    dm_wr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_err,
  output logic                    conflict,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W+PAR_W-1:0] mem_wdata,
  input  logic [DATA_W+PAR_W-1:0] mem_rdata,
  output logic                    par_err
);

  localparam int unsigned MW = DATA_W + PAR_W;

  dm_state_e         state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;
  logic              conflict_q, conflict_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic              par_err_d;
  logic [MW-1:0]     wr_word;
  logic              rd_par_bad;
  logic              out_of_range;

`ifdef PARITY_CHK_EN
  logic wr_par;
  logic par_err_q;

  dm_parity #(.DATA_W(DATA_W)) u_parity (
    .wr_data (wr_data),
    .wr_par  (wr_par),
    .rd_word (mem_rdata),
    .rd_bad  (rd_par_bad)
  );

  assign wr_word = {wr_par, wr_data};
  assign par_err = par_err_q;
`else
  assign wr_word    = wr_data;
  assign rd_par_bad = 1'b0;
  assign par_err    = 1'b0;
`endif

  // Widened so the compare also works when DEPTH equals 2**ADDR_W.
  assign out_of_range = 33'(dm_addr) >= 33'(DEPTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    conflict_d  = 1'b0;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    par_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_r || dm_wr) begin
          mem_addr_d  = dm_addr;
          mem_wdata_d = wr_word;
          conflict_d  = dm_r && dm_wr;
          if (out_of_range) begin
            state_d    = DONE;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d  = ACCESS;
            busy_d   = 1'b1;
            mem_ce_d = 1'b1;
            // Write wins when both strobes are set.
            mem_we_d = dm_wr;
            cnt_d    = WAIT_W'(WAIT_CYC);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!mem_we_q) begin
            rd_data_d = mem_rdata[DATA_W-1:0];
            par_err_d = rd_par_bad;
          end
        end else begin
          cnt_d    = cnt_q - WAIT_W'(1);
          busy_d   = 1'b1;
          mem_ce_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      DONE: begin
        // Requests in the done cycle are dropped; IDLE accepts from next cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      conflict_q  <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      conflict_q  <= conflict_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
    end
  end

`ifdef PARITY_CHK_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
`else
  logic unused_par;
  assign unused_par = par_err_d ^ rd_par_bad;
`endif

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign conflict  = conflict_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
module tb_dm_ctrl;
  import dm_pkg::*;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 1024;
  localparam int unsigned W   = 2;
  localparam int unsigned MW  = DW + PAR_W;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] dm_addr = '0;
  logic          dm_r = 1'b0;
  logic          dm_wr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          busy, done, addr_err, conflict, mem_ce, mem_we, par_err;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata;

  logic [MW-1:0] sram [DEP];
  logic [MW-1:0] flip = '0;
  logic          tb_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dm_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .WAIT_CYC(W)) dut (
    .clock     (clock),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_r      (dm_r),
    .dm_wr     (dm_wr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .conflict  (conflict),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .par_err   (par_err)
  );

  // Behavioural SRAM.
  always @(posedge clock) begin
    if (tb_clr) begin
      for (int i = 0; i < int'(DEP); i++) sram[i] <= '0;
    end else if (mem_ce && mem_we) begin
      sram[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = sram[mem_addr[9:0]] ^ flip;

  typedef struct {
    logic          r;
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    int            we_n;
    int            ce_n;
    int            conf_n;
    logic          err;
    logic          par;
    logic [DW-1:0] rd;
  } vec_t;

  // Reference model state.
  logic [DW-1:0] exp_mem [DEP];
  logic [DW-1:0] exp_rd = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected outcome of one request derived from the access rules.
  function automatic vec_t predict(input logic r, input logic w, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
    vec_t v;
    logic inr;
    inr = a < AW'(DEP);
    v.r = r; v.w = w; v.addr = a; v.wdata = d;
    v.lat    = inr ? int'(W) + 2 : 1;
    v.ce_n   = inr ? int'(W) + 1 : 0;
    v.we_n   = (inr && w) ? int'(W) + 1 : 0;
    v.conf_n = (r && w) ? 1 : 0;
    v.err    = !inr;
    v.par    = 1'b0;
    v.rd     = (inr && r && !w) ? exp_mem[a[9:0]] : exp_rd;
    return v;
  endfunction

  function automatic void model_update(input vec_t v);
    if (v.addr < AW'(DEP) && v.w) exp_mem[v.addr[9:0]] = v.wdata;
    exp_rd = v.rd;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int lat, we_n, ce_n, conf_n;
    logic err_s, par_s, busy_s;
    lat = 0; we_n = 0; ce_n = 0; conf_n = 0;
    err_s = 1'b0; par_s = 1'b0; busy_s = 1'b0;
    @(negedge clock);
    dm_r = v.r; dm_wr = v.w; dm_addr = v.addr; wr_data = v.wdata;
    @(posedge clock);
    #1 dm_r = 1'b0; dm_wr = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clock);
      if (mem_we) we_n++;
      if (mem_ce) ce_n++;
      if (conflict) conf_n++;
      if (done) begin
        lat = k; err_s = addr_err; par_s = par_err; busy_s = busy;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " mem_we cycles"}, we_n, v.we_n);
    check({tag, " mem_ce cycles"}, ce_n, v.ce_n);
    check({tag, " conflict pulses"}, conf_n, v.conf_n);
    check({tag, " addr_err"}, 32'(err_s), 32'(v.err));
    check({tag, " par_err"}, 32'(par_s), 32'(v.par));
    check({tag, " busy at done"}, 32'(busy_s), 0);
    check({tag, " rd_data"}, 32'(rd_data), 32'(v.rd));
    @(negedge clock);
    check({tag, " done width"}, 32'(done), 0);
    check({tag, " rd_data hold"}, 32'(rd_data), 32'(v.rd));
  endtask

  vec_t tbl [10];
  vec_t v;
  int   dones;

  initial begin
    for (int i = 0; i < int'(DEP); i++) exp_mem[i] = '0;

    // Fixed vectors, expectations written out by hand (WAIT_CYC=2, DEPTH=1024).
    //             r     w     addr        wdata  lat we ce cf err   par   rd
    tbl[0] = '{1'b0, 1'b1, 20'h00010, 8'hA5, 4, 3, 3, 0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 20'h00010, 8'h00, 4, 0, 3, 0, 1'b0, 1'b0, 8'hA5};
    tbl[2] = '{1'b1, 1'b1, 20'h00003, 8'h3C, 4, 3, 3, 1, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{1'b1, 1'b0, 20'h00003, 8'h00, 4, 0, 3, 0, 1'b0, 1'b0, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 20'h00400, 8'h00, 1, 0, 0, 0, 1'b1, 1'b0, 8'h3C};
    tbl[5] = '{1'b0, 1'b1, 20'h003FF, 8'h5A, 4, 3, 3, 0, 1'b0, 1'b0, 8'h3C};
    tbl[6] = '{1'b1, 1'b0, 20'h003FF, 8'h00, 4, 0, 3, 0, 1'b0, 1'b0, 8'h5A};
    tbl[7] = '{1'b0, 1'b1, 20'h00400, 8'h77, 1, 0, 0, 0, 1'b1, 1'b0, 8'h5A};
    tbl[8] = '{1'b1, 1'b0, 20'h00000, 8'h00, 4, 0, 3, 0, 1'b0, 1'b0, 8'h00};
    tbl[9] = '{1'b1, 1'b1, 20'h007FF, 8'h11, 1, 0, 0, 1, 1'b1, 1'b0, 8'h00};

    tb_clr = 1'b1;
    @(posedge clock);
    #1 tb_clr = 1'b0;
    @(negedge clock);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset addr_err", 32'(addr_err), 0);
    check("reset conflict", 32'(conflict), 0);
    check("reset mem_ce", 32'(mem_ce), 0);
    check("reset mem_we", 32'(mem_we), 0);
    check("reset rd_data", 32'(rd_data), 0);
    check("reset par_err", 32'(par_err), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    #2 rst = 1'b0;

    foreach (tbl[i]) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
      model_update(tbl[i]);
    end

    // Request while busy: the second read must be dropped.
    @(negedge clock);
    dm_r = 1'b1; dm_addr = 20'h00010;
    @(posedge clock);
    #1 dm_r = 1'b0;
    @(negedge clock);
    @(negedge clock);
    dm_r = 1'b1; dm_addr = 20'h003FF;
    @(posedge clock);
    #1 dm_r = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("busy drop done count", dones, 1);
    check("busy drop rd_data", 32'(rd_data), 32'h A5);
    exp_rd = 8'hA5;

    // Reset in the middle of an access.
    @(negedge clock);
    dm_r = 1'b1; dm_addr = 20'h003FF;
    @(posedge clock);
    #1 dm_r = 1'b0;
    @(negedge clock);
    check("pre-reset mem_ce", 32'(mem_ce), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset mem_ce", 32'(mem_ce), 0);
    check("async reset busy", 32'(busy), 0);
    check("async reset rd_data", 32'(rd_data), 0);
    exp_rd = '0;
    @(negedge clock);
    #2 rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("reset abandons done", dones, 0);
    v = predict(1'b1, 1'b0, 20'h003FF, 8'h00);
    run_vec("post-reset read", v);
    model_update(v);

`ifdef PARITY_CHK_EN
    flip = MW'(1);
    v = predict(1'b1, 1'b0, 20'h003FF, 8'h00);
    v.par = 1'b1;
    v.rd = v.rd ^ 8'h01;
    run_vec("parity bad read", v);
    model_update(v);
    flip = '0;
    v = predict(1'b1, 1'b0, 20'h003FF, 8'h00);
    run_vec("parity clean read", v);
    model_update(v);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int op;
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = AW'(DEP + $urandom_range(0, 100));
      else                           a = AW'($urandom_range(0, 7) * 37);
      d = DW'($urandom);
      v = predict(op != 1, op == 1 || op == 2, a, d);
      run_vec($sformatf("rand%0d", n), v);
      model_update(v);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
